instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 8, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; memory depth is 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc_addr  input  ADDR_W  fetch address from the program counter.
REQ-006 SHALL have port pc_valid  input  1  pc_addr is valid this cycle.
REQ-007 SHALL have port pc_ready  output  1  block accepts pc_addr this cycle.
REQ-008 SHALL have port prog_we  input  1  instruction-memory write enable.
REQ-009 SHALL have port prog_addr  input  ADDR_W  memory write address.
REQ-010 SHALL have port prog_data  input  DATA_W  memory write data.
REQ-011 SHALL have port flush  input  1  discard all buffered and in-flight fetches.
REQ-012 SHALL have port instr  output  DATA_W  instruction at FIFO head.
REQ-013 SHALL have port instr_addr  output  ADDR_W  address the head instruction was fetched from.
REQ-014 SHALL have port instr_valid  output  1  head entry is valid.
REQ-015 SHALL have port instr_ready  input  1  downstream consumes head this cycle.
REQ-016 SHALL have port occupancy  output  3  FIFO entries held, 0..4.

Function
REQ-017 SHALL hold a 2**ADDR_W x DATA_W memory; write at rising edge when prog_we=1; contents not reset.
REQ-018 SHALL accept an address (accept) at an edge where pc_valid=1 and pc_ready=1.
REQ-019 SHALL perform a synchronous read on accept; data and address captured as the in-flight entry at that edge.
REQ-020 SHALL push the in-flight entry into a 4-entry FIFO at the next edge; accept at edge N gives instr_valid=1 after edge N+1 when FIFO was empty (latency 1).
REQ-021 SHALL drive pc_ready = (occupancy + inflight < 4) and flush=0, registered terms only; no combinational path from instr_ready to pc_ready.
REQ-022 SHALL sustain one accept per cycle while instr_ready is held 1.
REQ-023 SHALL pop the head at an edge where instr_valid=1 and instr_ready=1; push and pop at the same edge leave occupancy unchanged.
REQ-024 SHALL keep instr and instr_addr stable while instr_valid=1 and instr_ready=0.
REQ-025 SHALL drive instr=0 and instr_addr=0 when occupancy=0.
REQ-026 SHALL return old memory data when prog_we and a read hit the same address in the same cycle (read-before-write).
REQ-027 SHALL, at an edge with flush=1, clear FIFO, occupancy and in-flight entry, ignore any pop, and accept no address; prog_we writes still occur.
REQ-028 SHALL wrap FIFO read/write pointers modulo 4; occupancy never exceeds 4 nor goes below 0.
REQ-029 SHALL never push when full; REQ-021 guarantees space for the in-flight entry.

Reset
REQ-030 SHALL, at an edge with reset=0, set occupancy=0, inflight=0, pointers=0, instr_valid=0, instr=0, instr_addr=0.
REQ-031 SHALL give reset priority over flush, accept and pop; memory contents unchanged by reset.
REQ-032 SHALL drive pc_ready=1 at the first edge after reset returns to 1.

Verification
REQ-033 Load mem[i]=8'h10+i for i=0..7, reset, stream pc_addr 0..7 with instr_ready=1 -> instr 8'h10..8'h17 in order, one per cycle, first one edge after first accept.
REQ-034 instr_ready=0, pc_valid=1 continuously -> exactly 4 accepts, occupancy=4, pc_ready=0, head instr stable at 8'h10.
REQ-035 Occupancy=3, flush=1 with pc_valid=1 and instr_ready=1 -> next cycle occupancy=0, instr_valid=0, no accept, next accept resumes normally.
REQ-036 prog_we to addr 5 with data 8'hAA while fetching addr 5 -> old value returned; re-fetch of addr 5 returns 8'hAA.
REQ-037 reset=0 asserted with occupancy=2 and an in-flight read -> all outputs zero next cycle, memory retains loaded data, first fetch after release correct.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program-loaded instruction memory, one-deep
// synchronous read stage and a 4-entry output FIFO with valid/ready handshakes.
module instr_fetch #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              flush,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [2:0]        occupancy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid never waits on ready, and ready never depends on
   // instr_ready so the fetch and consume sides cannot form a loop.

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int FIFO_D = 4;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] fifo_data_q [FIFO_D];
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_D];

   logic [1:0]        wr_ptr_q, wr_ptr_d;
   logic [1:0]        rd_ptr_q, rd_ptr_d;
   logic [2:0]        occ_q, occ_d;

   logic              infl_q;
   logic [DATA_W-1:0] infl_data_q;
   logic [ADDR_W-1:0] infl_addr_q;

   logic [3:0]        level;
   logic              accept;
   logic              push;
   logic              pop;

   // Space must cover the entry already in flight, so count it against the FIFO.
   always_comb begin
      level       = {1'b0, occ_q} + {3'b000, infl_q};
      pc_ready    = (level < 4'd4) && !flush;
      accept      = pc_valid && pc_ready;
      instr_valid = (occ_q != 3'd0);
      pop         = instr_valid && instr_ready && !flush;
      push        = infl_q && !flush;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
         occ_d    = 3'd0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
         case ({push, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_comb begin
      instr      = '0;
      instr_addr = '0;
      if (instr_valid) begin
         instr      = fifo_data_q[rd_ptr_q];
         instr_addr = fifo_addr_q[rd_ptr_q];
      end
      occupancy = occ_q;
   end

   // Memory is never reset; programming continues through reset and flush.
   always_ff @(posedge clk) begin
      if (prog_we) mem_q[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset && push) begin
         fifo_data_q[wr_ptr_q] <= infl_data_q;
         fifo_addr_q[wr_ptr_q] <= infl_addr_q;
      end
   end

   // The read samples mem_q before this edge's write lands: read-before-write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         occ_q       <= 3'd0;
         infl_q      <= 1'b0;
         infl_data_q <= '0;
         infl_addr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         infl_q   <= accept;
         if (accept) begin
            infl_data_q <= mem_q[pc_addr];
            infl_addr_q <= pc_addr;
         end
      end
   end

   occ_bound_a : assert property (@(posedge clk) disable iff (!reset)
      occ_q <= 3'd4);
   no_push_full_a : assert property (@(posedge clk) disable iff (!reset)
      !(push && occ_q == 3'd4));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, back-pressure, flush,
// read-before-write and mid-traffic reset, all checked against hand values.
module tb_instr_fetch;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] pc_addr;
   logic              pc_valid;
   logic              pc_ready;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              flush;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_addr;
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        occupancy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] exp_q[$];

   instr_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_addr     (pc_addr),
      .pc_valid    (pc_valid),
      .pc_ready    (pc_ready),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .flush       (flush),
      .instr       (instr),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .occupancy   (occupancy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic [7:0] d, input logic [2:0] a);
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_instr"}, 32'(instr), 32'(d));
      check({tag, "_addr"}, 32'(instr_addr), 32'(a));
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_occ"}, 32'(occupancy), 32'd0);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_instr"}, 32'(instr), 32'd0);
      check({tag, "_addr"}, 32'(instr_addr), 32'd0);
   endtask

   // driver
   task automatic drive(input logic v, input logic [2:0] a, input logic rdy);
      pc_valid    = v;
      pc_addr     = a;
      instr_ready = rdy;
   endtask

   initial begin
      int acc;
      logic [7:0] exp_d;
      reset = 1'b0; flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      drive(1'b0, 3'd0, 1'b0);

      // Program memory while held in reset.
      for (int i = 0; i < 8; i++) begin
         prog_we = 1'b1; prog_addr = 3'(i); prog_data = 8'h10 + 8'(i);
         tick();
      end
      prog_we = 1'b0;
      check_empty("reset");
      reset = 1'b1;
      tick();
      check("ready_after_reset", 32'(pc_ready), 32'd1);

      // Stream 0..7 with the consumer always ready.
      instr_ready = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         pc_valid = (k < 8);
         pc_addr  = 3'(k);
         if (k < 8) exp_q.push_back(8'h10 + 8'(k));
         tick();
         if (k == 0) begin
            check("stream_lat", 32'(instr_valid), 32'd0);
         end else begin
            exp_d = exp_q.pop_front();
            check_head("stream", exp_d, 3'(k - 1));
            check("stream_occ", 32'(occupancy), 32'd1);
         end
      end
      drive(1'b0, 3'd0, 1'b1);
      tick();
      check_empty("stream_done");

      // Back-pressure: only four accepts fit.
      acc = 0;
      instr_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pc_valid = 1'b1;
         pc_addr  = 3'(i);
         #1;
         if (pc_ready) acc++;
         tick();
      end
      check("bp_accepts", 32'(acc), 32'd4);
      check("bp_occ", 32'(occupancy), 32'd4);
      check("bp_ready", 32'(pc_ready), 32'd0);
      check_head("bp_head", 8'h10, 3'd0);

      // Pop one to reach occupancy 3, then flush under full traffic.
      drive(1'b0, 3'd0, 1'b1);
      tick();
      check("pre_flush_occ", 32'(occupancy), 32'd3);
      check_head("pre_flush", 8'h11, 3'd1);
      drive(1'b1, 3'd5, 1'b1);
      flush = 1'b1;
      #1;
      check("flush_ready", 32'(pc_ready), 32'd0);
      tick();
      flush = 1'b0;
      pc_valid = 1'b0;
      check_empty("flush");
      drive(1'b1, 3'd6, 1'b0);
      tick();
      check("resume_occ0", 32'(occupancy), 32'd0);
      drive(1'b0, 3'd0, 1'b0);
      tick();
      check_head("resume", 8'h16, 3'd6);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;

      // Write and read address 5 in the same cycle.
      drive(1'b1, 3'd5, 1'b0);
      prog_we = 1'b1; prog_addr = 3'd5; prog_data = 8'hAA;
      tick();
      prog_we = 1'b0;
      pc_valid = 1'b0;
      tick();
      check_head("rbw_old", 8'h15, 3'd5);
      drive(1'b1, 3'd5, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      tick();
      check_head("rbw_new", 8'hAA, 3'd5);
      instr_ready = 1'b1;
      tick();
      check("rbw_drain", 32'(occupancy), 32'd0);

      // Reset with two buffered entries and one read in flight.
      instr_ready = 1'b0;
      for (int a = 2; a <= 4; a++) begin
         drive(1'b1, 3'(a), 1'b0);
         tick();
      end
      check("pre_rst_occ", 32'(occupancy), 32'd2);
      pc_valid = 1'b0;
      reset = 1'b0;
      tick();
      check_empty("mid_rst");
      reset = 1'b1;
      tick();
      check("rst_rel_ready", 32'(pc_ready), 32'd1);
      check("rst_rel_occ", 32'(occupancy), 32'd0);
      drive(1'b1, 3'd7, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      tick();
      check_head("post_rst", 8'h17, 3'd7);
      drive(1'b1, 3'd5, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0);
      tick();
      check_head("mem_kept", 8'hAA, 3'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
